// File: rtl/grant_scheduler.sv
// Sticky round-robin grant scheduler: one owner at a time, held until release_grant.
// Define GRANT_SCHED_BYPASS_EN to re-arbitrate on release with no idle bubble.
module grant_scheduler #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter string       DIRECTION      = "LSB0",
  parameter int unsigned INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      release_grant,
  output logic                      grant_valid,
  output logic [INDEX_WIDTH-1:0]    grant_idx,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);

`ifdef GRANT_SCHED_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  localparam int unsigned SumW = INDEX_WIDTH + 1;
  localparam logic [NUM_REQUESTERS-1:0] OhOne = {{(NUM_REQUESTERS-1){1'b0}}, 1'b1};
  localparam logic [INDEX_WIDTH-1:0]    LastIdx = INDEX_WIDTH'(NUM_REQUESTERS - 1);

  typedef enum logic [0:0] {StIdle, StGranted} state_e;

  state_e                    state_q, state_d;
  logic [INDEX_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic [INDEX_WIDTH-1:0]    grant_idx_q, grant_idx_d;
  logic [NUM_REQUESTERS-1:0] grant_oh_q, grant_oh_d;

  logic [INDEX_WIDTH-1:0]    release_ptr;
  logic [INDEX_WIDTH-1:0]    arb_ptr;
  logic [NUM_REQUESTERS-1:0] req_rot;
  logic                      win_found;
  logic [SumW-1:0]           win_off;
  logic [SumW-1:0]           win_sum;
  logic [INDEX_WIDTH-1:0]    win_idx;
  logic [INDEX_WIDTH-1:0]    win_shift;
  logic [NUM_REQUESTERS-1:0] win_oh;

  assign release_ptr = (grant_idx_q == LastIdx) ? '0 : grant_idx_q + 1'b1;

  // With bypass, the releasing cycle already arbitrates from the post-release pointer.
  assign arb_ptr = (Bypass && state_q == StGranted && release_grant) ? release_ptr : rr_ptr_q;

  // Rotate so bit 0 is the highest-priority requester, then find the first set bit.
  assign req_rot = NUM_REQUESTERS'({request, request} >> arb_ptr);

  always_comb begin
    win_found = 1'b0;
    win_off   = '0;
    for (int unsigned j = 0; j < NUM_REQUESTERS; j++) begin
      if (!win_found && req_rot[j]) begin
        win_found = 1'b1;
        win_off   = SumW'(j);
      end
    end
    win_sum = {1'b0, arb_ptr} + win_off;
    if (win_sum >= SumW'(NUM_REQUESTERS)) begin
      win_sum = win_sum - SumW'(NUM_REQUESTERS);
    end
    win_idx   = win_sum[INDEX_WIDTH-1:0];
    win_shift = (DIRECTION == "LSB0") ? win_idx : LastIdx - win_idx;
    win_oh    = OhOne << win_shift;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    grant_oh_d  = grant_oh_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d     = StGranted;
          grant_idx_d = win_idx;
          grant_oh_d  = win_oh;
        end
      end
      StGranted: begin
        if (release_grant) begin
          rr_ptr_d = release_ptr;
          if (Bypass && win_found) begin
            grant_idx_d = win_idx;
            grant_oh_d  = win_oh;
          end else begin
            state_d     = StIdle;
            grant_idx_d = '0;
            grant_oh_d  = '0;
          end
        end
      end
      default: begin
        state_d     = StIdle;
        grant_idx_d = '0;
        grant_oh_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      grant_oh_q  <= grant_oh_d;
    end
  end

  assign grant_valid = (state_q == StGranted);
  assign grant_idx   = grant_idx_q;
  assign grant_oh    = grant_oh_q;

endmodule
